// File: rtl/uart_tx_cfg.sv
// UART transmitter with runtime parity (none/even/odd), 1 or 2 stop bits and a
// one-entry holding register so frames can go out back-to-back.
module uart_tx_cfg #(
  parameter int DATA_BITS = 8,
  parameter int SB_TICKS  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tick,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] din,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  output logic                 tx_busy,
  output logic                 tx_done_tick,
  output logic                 tx
);

  // state  | meaning
  // IDLE   | line high, waiting for a buffered word
  // START  | start bit (line low)
  // DATA   | data bits, LSB first
  // PARITY | optional parity bit
  // STOP   | one or two stop bit periods (line high)
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int SW = $clog2(2 * SB_TICKS);
  localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [SW-1:0] BIT_LAST   = SW'(SB_TICKS - 1);
  localparam logic [SW-1:0] STOP2_LAST = SW'(2 * SB_TICKS - 1);
  localparam logic [NW-1:0] N_LAST     = NW'(DATA_BITS - 1);

  state_t               state;
  logic [SW-1:0]        s_reg;
  logic [NW-1:0]        n_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] hold_data;
  logic                 hold_valid;
  logic                 par_en;
  logic                 par_bit;
  logic                 stop2_reg;

  logic                 bit_end;
  logic [SW-1:0]        stop_last;
  logic                 frame_end;
  logic                 load;
  logic                 par_on;
  logic                 par_val;

  assign bit_end      = s_tick && (s_reg == BIT_LAST);
  assign stop_last    = stop2_reg ? STOP2_LAST : BIT_LAST;
  assign frame_end    = (state == STOP) && s_tick && (s_reg == stop_last);
  assign load         = hold_valid && ((state == IDLE) || frame_end);
  assign par_on       = (parity_mode == 2'b01) || (parity_mode == 2'b10);
  assign par_val      = (parity_mode == 2'b10) ? ~^hold_data : ^hold_data;

  assign tx_ready     = !hold_valid;
  assign tx_busy      = (state != IDLE);
  assign tx_done_tick = frame_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      s_reg      <= '0;
      n_reg      <= '0;
      shift_reg  <= '0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      par_en     <= 1'b0;
      par_bit    <= 1'b0;
      stop2_reg  <= 1'b0;
      tx         <= 1'b1;
    end else begin
      if (tx_valid && !hold_valid) begin
        hold_data  <= din;
        hold_valid <= 1'b1;
      end

      // A load at frame end skips IDLE entirely, so the next start bit
      // follows the last stop tick with no extra high time.
      if (load) begin
        shift_reg  <= hold_data;
        hold_valid <= 1'b0;
        state      <= START;
        s_reg      <= '0;
        n_reg      <= '0;
        par_en     <= par_on;
        par_bit    <= par_val;
        stop2_reg  <= stop2;
      end else begin
        case (state)
          IDLE: begin
            s_reg <= '0;
          end
          START: begin
            if (bit_end) begin
              state <= DATA;
              s_reg <= '0;
              n_reg <= '0;
            end else if (s_tick) begin
              s_reg <= s_reg + SW'(1);
            end
          end
          DATA: begin
            if (bit_end) begin
              s_reg     <= '0;
              shift_reg <= shift_reg >> 1;
              if (n_reg == N_LAST) begin
                state <= par_en ? PARITY : STOP;
              end else begin
                n_reg <= n_reg + NW'(1);
              end
            end else if (s_tick) begin
              s_reg <= s_reg + SW'(1);
            end
          end
          PARITY: begin
            if (bit_end) begin
              state <= STOP;
              s_reg <= '0;
            end else if (s_tick) begin
              s_reg <= s_reg + SW'(1);
            end
          end
          STOP: begin
            if (frame_end) begin
              state <= IDLE;
              s_reg <= '0;
            end else if (s_tick) begin
              s_reg <= s_reg + SW'(1);
            end
          end
          default: begin
            state <= IDLE;
            s_reg <= '0;
          end
        endcase
      end

      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shift_reg[0];
        PARITY:  tx <= par_bit;
        default: tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter in the UART block.
- Adds a runtime-selectable parity bit (none/even/odd) and 1 or 2 stop bits.
- Adds a one-entry holding register with a valid/ready handshake, so frames can go out back-to-back with no idle gap.
- Sits between the debug-unit command/response logic and the tx pin, driven by the shared baud-rate tick generator.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
SB_TICKS, 16, s_tick pulses per bit period; legal range >= 2.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-high reset.
s_tick  input  1  oversampling tick from the baud generator; one-clk pulse.
tx_valid  input  1  din holds a word to send.
tx_ready  output  1  holding register empty; a word is accepted when tx_valid && tx_ready at a clk edge.
din  input  DATA_BITS  word to transmit.
parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none.
stop2  input  1  0 = one stop bit, 1 = two stop bits.
tx_busy  output  1  high whenever state != IDLE.
tx_done_tick  output  1  one-clk pulse at the end of each frame's stop period.
tx  output  1  serial line; registered; idles high.

Behaviour:
- Reset (async): state=IDLE, counters=0, shift register=0, hold_valid=0, tx=1, tx_busy=0, tx_done_tick=0, tx_ready=1. Reset mid-frame aborts the frame immediately; the line returns high with no partial stop bit. The buffered word is discarded.
- Handshake:
  - tx_ready = !hold_valid (combinational).
  - Acceptance writes din into hold_data and sets hold_valid.
  - din and tx_valid are ignored when tx_ready=0.
  - Input values are don't-care when tx_valid=0.
- Frame load happens in IDLE when hold_valid=1, and also at the frame end (see STOP):
  - shift_reg <= hold_data; hold_valid <= 0; state <= START; s_reg <= 0.
  - Latch par_en = (parity_mode==01 || parity_mode==10) and stop2.
  - Latch par_bit = ^hold_data for even, ~^hold_data for odd.
  - Configuration inputs changed mid-frame do not affect the frame in flight.
- tx is registered from the current state, so the line lags the state by one clk:
  - START drives 0.
  - DATA drives shift_reg[0].
  - PARITY drives par_bit.
  - STOP and IDLE drive 1.
- Bit timing:
  - s_reg counts s_ticks within a bit; a bit ends on the s_tick where s_reg == SB_TICKS-1.
  - s_tick is ignored in IDLE.
  - With no s_tick the FSM holds its state.
- State transitions:
  - START: at bit end, go to DATA with s_reg=0, n_reg=0.
  - DATA: at bit end, shift_reg >>= 1.
    - If n_reg == DATA_BITS-1, go to PARITY when par_en, else STOP.
    - Otherwise n_reg++.
  - PARITY: at bit end, go to STOP with s_reg=0.
  - STOP: lasts SB_TICKS ticks, or 2*SB_TICKS when stop2 is latched; s_reg spans 0..2*SB_TICKS-1.
- Frame end (last STOP tick):
  - tx_done_tick=1 for that clk (combinational, Mealy).
  - If hold_valid=1 on that same cycle, load directly (back-to-back): next state is START, with no IDLE cycle and no extra high time.
  - Otherwise go to IDLE.
  - A word accepted on the frame-end cycle is not loaded that cycle; it is loaded from IDLE on the next clk.
- Frame length in s_ticks = SB_TICKS × (1 + DATA_BITS + par_en + 1 + stop2).
- Counter widths:
  - s_reg: $clog2(2*SB_TICKS).
  - n_reg: $clog2(DATA_BITS), minimum 1.
  - Comparisons are width-safe; counters never wrap within a frame.
- Throughput: at most one word in flight plus one buffered; tx_ready rises one clk after a load.

Test Plan:
- 8N1, din=0xA5, SB_TICKS=16, s_tick every clk:
  - tx reads 0 | 1,0,1,0,0,1,0,1 | 1, each bit 16 clks.
  - tx_done_tick pulses once, 160 ticks after START entry.
  - tx_busy falls the next clk.
- 8E2 then 8O1 with din=0xA5:
  - Even: parity bit = 0, stop high for 32 ticks, frame = 192 ticks.
  - Odd: parity bit = 1, frame = 176 ticks.
- Back-to-back: send 0x55, and present 0x0F while the first frame is in DATA:
  - tx_ready drops until the load.
  - The second START begins on the clk after the first tx_done_tick, with exactly 16 ticks of stop high between frames.
- Hold full: with hold_valid=1, drive tx_valid with 0x33:
  - Not accepted, tx_ready=0.
  - After the frame end it is accepted on a later clk and transmitted intact.
- Reset mid-DATA (after bit 3 of 0xFF):
  - tx=1 within the reset assertion, state IDLE, tx_ready=1, no tx_done_tick.
  - The next frame after reset is transmitted correctly.
- Config change mid-frame: switch parity_mode 00→01 and stop2 0→1 during DATA:
  - The current frame stays 8N1 (160 ticks).
  - The next frame uses 8E2 (192 ticks).
